bram_loader: RTL and testbench
==============================

BRAM_LOADER -- requirements
Module: bram_loader

Interface
REQ-001 Parameters SHALL be: CNT_BIT 31 (run-count width); DWIDTH 32 (BRAM0 word width); AWIDTH 8 (BRAM0 address width); MEM_SIZE 256 (BRAM0 depth in words).
REQ-002 clk  in  1  single clock; all state is updated on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 s_valid_i  in  1  upstream word valid.
REQ-005 s_ready_o  out  1  loader can accept a word.
REQ-006 s_data_i  in  DWIDTH  upstream word.
REQ-007 s_last_i  in  1  final word of the frame, qualified by s_valid_i.
REQ-008 addr_b0_o  out  AWIDTH  BRAM0 write address.
REQ-009 ce_b0_o / we_b0_o  out  1 each  BRAM0 chip enable and write enable.
REQ-010 d_b0_o  out  DWIDTH  BRAM0 write data.
REQ-011 start_run_o  out  1  one-cycle start pulse to the BRAM accessor.
REQ-012 run_count_o  out  CNT_BIT  number of words loaded, presented to the accessor.
REQ-013 acc_done_i  in  1  accessor done pulse.
REQ-014 idle_o / load_o / wait_o / done_o  out  1 each  one-hot state flags.
REQ-015 overflow_o  out  1  frame truncated at MEM_SIZE words.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, KICK, WAIT and DONE, and SHALL drive exactly one of idle_o, load_o, wait_o or done_o high per state; KICK drives load_o.
REQ-017 IDLE: s_ready_o=1; the first handshake (s_valid_i & s_ready_o) writes address 0 and moves the FSM to LOAD; overflow_o clears on that beat.
REQ-018 In IDLE and LOAD, s_ready_o SHALL be 1; in KICK, WAIT and DONE it SHALL be 0.
REQ-019 BRAM0 writes SHALL be combinational on each handshake: ce_b0_o=we_b0_o=1, addr_b0_o=wr_ptr, d_b0_o=s_data_i; otherwise ce, we and d SHALL be 0.
REQ-020 wr_ptr SHALL start at 0 and increment by 1 per handshake; word count (AWIDTH+1 bits) SHALL equal wr_ptr+1 after each write.
REQ-021 A handshake with s_last_i=1 SHALL move the FSM to KICK on the next edge.
REQ-022 On the MEM_SIZE-th handshake with s_last_i=0, the FSM SHALL move to KICK and set overflow_o=1 (sticky until the next frame starts); wr_ptr SHALL wrap to 0 and no further write SHALL occur.
REQ-023 If the MEM_SIZE-th handshake has s_last_i=1, overflow_o SHALL stay 0.
REQ-024 KICK SHALL last exactly 1 cycle, with start_run_o=1 and run_count_o=word count zero-extended to CNT_BIT; the FSM then moves to WAIT.
REQ-025 Outside KICK, start_run_o SHALL be 0 and run_count_o SHALL be 0.
REQ-026 WAIT SHALL hold until acc_done_i=1, then move to DONE; acc_done_i in any other state SHALL be ignored.
REQ-027 DONE SHALL last 1 cycle with done_o=1, then return to IDLE with wr_ptr=0.
REQ-028 End-to-end latency SHALL be: last handshake at edge N -> start_run_o high during cycle N+1.
REQ-029 s_valid_i while s_ready_o=0 SHALL have no effect; upstream holds the word.

Reset
REQ-030 While reset=1, regardless of clock, the FSM SHALL be IDLE, wr_ptr=0, overflow_o=0 and start_run_o=0, and all BRAM outputs SHALL be 0; idle_o=1 and s_ready_o=1.
REQ-031 Reset asserted mid-LOAD or mid-WAIT SHALL abandon the frame with no start pulse; the next frame SHALL begin at address 0.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (3-bit, 5 states) and the default parameter constants, so the accessor and the loader share them.
REQ-033 The block SHALL be a single module, with no sub-modules.

Verification
REQ-034 Reset release, then 4 words 0x11..0x14 with last on the 4th -> writes at addresses 0..3; start_run_o for 1 cycle with run_count_o=4; overflow_o=0.
REQ-035 256 words 1..256 with last on the 256th -> run_count_o=256, overflow_o=0, final write at address 255.
REQ-036 300 words with no last -> 256 writes, then KICK with run_count_o=256 and overflow_o=1; s_ready_o=0 afterwards.
REQ-037 Frame loaded, FSM in WAIT, acc_done_i pulsed after 20 cycles -> done_o high 1 cycle, then idle_o=1; a new frame writes address 0 and clears overflow_o.
REQ-038 reset asserted after 10 words of LOAD -> no start_run_o; the next 2-word frame gives run_count_o=2 and writes addresses 0..1.
REQ-039 s_valid_i toggled randomly, with valid high during WAIT -> no BRAM write and no pointer change outside IDLE/LOAD.

Source files
------------

// File: rtl/bram_loader_pkg.sv
// Shared definitions for the BRAM0 loader and the BRAM accessor it kicks.
package bram_loader_pkg;

    // Default geometry shared by loader and accessor.
    localparam int BL_CNT_BIT  = 31;
    localparam int BL_DWIDTH   = 32;
    localparam int BL_AWIDTH   = 8;
    localparam int BL_MEM_SIZE = 256;

    // Loader FSM encoding; the accessor decodes the same values.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_KICK = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } bl_state_t;

endpackage

// File: rtl/bram_loader.sv
// Streams one upstream frame into BRAM0 starting at address 0, then pulses
// start_run_o with the word count and waits for the accessor to finish.
// Frames longer than MEM_SIZE words are truncated and flagged by overflow_o.
module bram_loader
    import bram_loader_pkg::*;
#(
    parameter int CNT_BIT  = BL_CNT_BIT,
    parameter int DWIDTH   = BL_DWIDTH,
    parameter int AWIDTH   = BL_AWIDTH,
    parameter int MEM_SIZE = BL_MEM_SIZE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_valid_i,
    output logic               s_ready_o,
    input  logic [DWIDTH-1:0]  s_data_i,
    input  logic               s_last_i,
    output logic [AWIDTH-1:0]  addr_b0_o,
    output logic               ce_b0_o,
    output logic               we_b0_o,
    output logic [DWIDTH-1:0]  d_b0_o,
    output logic               start_run_o,
    output logic [CNT_BIT-1:0] run_count_o,
    input  logic               acc_done_i,
    output logic               idle_o,
    output logic               load_o,
    output logic               wait_o,
    output logic               done_o,
    output logic               overflow_o
);

    // Word count just before the final word that still fits in BRAM0.
    localparam logic [AWIDTH:0] LAST_IDX = (AWIDTH + 1)'(MEM_SIZE - 1);

    bl_state_t         state_q;
    bl_state_t         state_d;
    logic [AWIDTH-1:0] wr_ptr_q;
    logic [AWIDTH:0]   count_q;
    logic              overflow_q;
    logic              accept;
    logic              at_limit;

    // Handshake qualification; reset forces the write port quiet immediately.
    always_comb begin
        s_ready_o = (state_q == ST_IDLE) || (state_q == ST_LOAD);
        accept    = s_valid_i && s_ready_o && !reset;
        at_limit  = (count_q == LAST_IDX);
    end

    // Next-state decode plus all state-dependent outputs.
    always_comb begin
        state_d     = state_q;
        idle_o      = 1'b0;
        load_o      = 1'b0;
        wait_o      = 1'b0;
        done_o      = 1'b0;
        start_run_o = 1'b0;
        run_count_o = '0;
        ce_b0_o     = accept;
        we_b0_o     = accept;
        addr_b0_o   = accept ? wr_ptr_q : '0;
        d_b0_o      = accept ? s_data_i : '0;
        overflow_o  = overflow_q;

        case (state_q)
            ST_IDLE: begin
                idle_o = 1'b1;
                if (accept) begin
                    state_d = (s_last_i || at_limit) ? ST_KICK : ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_o = 1'b1;
                if (accept && (s_last_i || at_limit)) begin
                    state_d = ST_KICK;
                end
            end
            ST_KICK: begin
                load_o      = 1'b1;
                start_run_o = 1'b1;
                run_count_o = CNT_BIT'(count_q);
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                wait_o = 1'b1;
                if (acc_done_i) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                idle_o  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Write pointer, word count and sticky overflow flag.
    // Overflow is re-evaluated (not just cleared) on the first beat of a
    // frame so a MEM_SIZE of 1 still reports truncation correctly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr_q <= at_limit ? '0 : wr_ptr_q + AWIDTH'(1);
                count_q  <= count_q + (AWIDTH + 1)'(1);
                if (state_q == ST_IDLE) begin
                    overflow_q <= at_limit && !s_last_i;
                end else if (at_limit && !s_last_i) begin
                    overflow_q <= 1'b1;
                end
            end else if (state_q == ST_DONE) begin
                wr_ptr_q <= '0;
                count_q  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bram_loader.sv
// Self-checking bench for bram_loader: randomized frames against a
// frame-level reference model of what BRAM0 and the accessor should see.
module tb_bram_loader;

    localparam int CNT_BIT  = 31;
    localparam int DWIDTH   = 32;
    localparam int AWIDTH   = 8;
    localparam int MEM_SIZE = 256;

    logic               clk = 1'b0;
    logic               reset;
    logic               s_valid_i;
    logic               s_ready_o;
    logic [DWIDTH-1:0]  s_data_i;
    logic               s_last_i;
    logic [AWIDTH-1:0]  addr_b0_o;
    logic               ce_b0_o;
    logic               we_b0_o;
    logic [DWIDTH-1:0]  d_b0_o;
    logic               start_run_o;
    logic [CNT_BIT-1:0] run_count_o;
    logic               acc_done_i;
    logic               idle_o;
    logic               load_o;
    logic               wait_o;
    logic               done_o;
    logic               overflow_o;

    bram_loader #(
        .CNT_BIT (CNT_BIT),
        .DWIDTH  (DWIDTH),
        .AWIDTH  (AWIDTH),
        .MEM_SIZE(MEM_SIZE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .s_valid_i  (s_valid_i),
        .s_ready_o  (s_ready_o),
        .s_data_i   (s_data_i),
        .s_last_i   (s_last_i),
        .addr_b0_o  (addr_b0_o),
        .ce_b0_o    (ce_b0_o),
        .we_b0_o    (we_b0_o),
        .d_b0_o     (d_b0_o),
        .start_run_o(start_run_o),
        .run_count_o(run_count_o),
        .acc_done_i (acc_done_i),
        .idle_o     (idle_o),
        .load_o     (load_o),
        .wait_o     (wait_o),
        .done_o     (done_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          c;
        logic        ov;
    } wr_t;

    typedef struct {
        int   cnt;
        logic ov;
        logic ld;
        int   c;
    } kick_t;

    wr_t         wr_log[$];
    kick_t       kick_log[$];
    int          bad_port = 0;
    int          bad_hot  = 0;
    logic [31:0] frame[$];

    // Observe the DUT mid-cycle: log writes and start pulses, count rule breaks.
    always @(negedge clk) begin
        if (ce_b0_o === 1'b1) wr_log.push_back('{int'(addr_b0_o), d_b0_o, cyc, overflow_o});
        if (start_run_o === 1'b1) kick_log.push_back('{int'(run_count_o), overflow_o, load_o, cyc});
        if (ce_b0_o !== we_b0_o) bad_port++;
        if (ce_b0_o === 1'b0 && d_b0_o !== '0) bad_port++;
        if (ce_b0_o === 1'b1 && !(s_valid_i === 1'b1 && s_ready_o === 1'b1)) bad_port++;
        if (start_run_o === 1'b0 && run_count_o !== '0) bad_port++;
        if (int'(idle_o) + int'(load_o) + int'(wait_o) + int'(done_o) != 1) bad_hot++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Frame-level reference: how many words land in BRAM0 and whether truncated.
    function automatic void model_frame(input int n, input int last_pos, output int cnt, output bit ov);
        if (last_pos >= 0 && last_pos < MEM_SIZE) begin
            cnt = last_pos + 1;
            ov  = 1'b0;
        end else begin
            cnt = (n < MEM_SIZE) ? n : MEM_SIZE;
            ov  = 1'b1;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer frame words with random idle gaps; stop if a word is refused 8 cycles.
    task automatic drive_frame(input int n, input int last_pos, input int gap_pct,
                               input bit noise, output int accepted);
        accepted = 0;
        for (int i = 0; i < n; i++) begin
            int waited;
            bit took;
            while ($urandom_range(99) < gap_pct) begin
                s_valid_i  = 1'b0;
                s_data_i   = $urandom;
                s_last_i   = 1'($urandom_range(1));
                acc_done_i = noise && ($urandom_range(3) == 0);
                step();
            end
            s_valid_i  = 1'b1;
            s_data_i   = frame[i];
            s_last_i   = (i == last_pos);
            acc_done_i = noise && ($urandom_range(3) == 0);
            waited = 0;
            took   = 1'b0;
            while (!took && waited < 8) begin
                @(negedge clk);
                if (s_ready_o === 1'b1) begin
                    accepted++;
                    took = 1'b1;
                end else begin
                    waited++;
                end
                step();
            end
            if (!took) break;
        end
        s_valid_i  = 1'b0;
        s_last_i   = 1'b0;
        acc_done_i = 1'b0;
    endtask

    // Let the run reach WAIT, hold it, pulse acc_done_i, report what was seen.
    task automatic complete_run(input int hold, input bit noise, output int bad_wait,
                                output int saw_done, output int saw_idle, output int stray);
        int base;
        int tries;
        base     = wr_log.size();
        bad_wait = 0;
        tries    = 0;
        @(negedge clk);
        while (wait_o !== 1'b1 && tries < 4) begin
            tries++;
            step();
            @(negedge clk);
        end
        if (wait_o !== 1'b1) bad_wait++;
        step();
        repeat (hold) begin
            if (noise) begin
                s_valid_i = 1'($urandom_range(1));
                s_data_i  = $urandom;
                s_last_i  = 1'($urandom_range(1));
            end
            @(negedge clk);
            if (wait_o !== 1'b1) bad_wait++;
            step();
        end
        s_valid_i  = 1'b0;
        s_last_i   = 1'b0;
        acc_done_i = 1'b1;
        @(negedge clk);
        if (wait_o !== 1'b1) bad_wait++;
        step();
        acc_done_i = 1'b0;
        @(negedge clk);
        saw_done = int'(done_o);
        step();
        @(negedge clk);
        saw_idle = int'(idle_o);
        stray    = wr_log.size() - base;
        step();
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        s_valid_i  = 1'b1;
        s_data_i   = '1;
        s_last_i   = 1'b1;
        acc_done_i = 1'b1;
        repeat (3) step();
        @(negedge clk);
        n_cmp++;
        if ({idle_o, load_o, wait_o, done_o, s_ready_o, ce_b0_o, we_b0_o, start_run_o, overflow_o} !== 9'b1000_1000_0) begin
            n_bad++;
            $display("FAIL reset_flags got %b want %b",
                     {idle_o, load_o, wait_o, done_o, s_ready_o, ce_b0_o, we_b0_o, start_run_o, overflow_o}, 9'b1000_1000_0);
        end
        n_cmp++;
        if (addr_b0_o !== '0 || d_b0_o !== '0 || run_count_o !== '0) begin
            n_bad++;
            $display("FAIL reset_data got addr %h d %h cnt %0d want all zero", addr_b0_o, d_b0_o, run_count_o);
        end
        step();
        s_valid_i  = 1'b0;
        s_last_i   = 1'b0;
        acc_done_i = 1'b0;
        reset      = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_short_frame();
        int bw, bk, acc, cnt, bw8, sd, si, st;
        bit ov;
        frame.delete();
        for (int i = 0; i < 4; i++) frame.push_back(32'h11 + i);
        bw = wr_log.size();
        bk = kick_log.size();
        model_frame(4, 3, cnt, ov);
        drive_frame(4, 3, 30, 1'b0, acc);
        complete_run(3, 1'b0, bw8, sd, si, st);
        n_cmp++;
        if (wr_log.size() - bw !== cnt) begin
            n_bad++;
            $display("FAIL short_nwr got %0d want %0d", wr_log.size() - bw, cnt);
        end
        for (int i = 0; i < cnt && bw + i < wr_log.size(); i++) begin
            n_cmp++;
            if (wr_log[bw+i].addr !== i || wr_log[bw+i].data !== frame[i]) begin
                n_bad++;
                $display("FAIL short_wr[%0d] got a=%0d d=%h want a=%0d d=%h", i, wr_log[bw+i].addr, wr_log[bw+i].data, i, frame[i]);
            end
        end
        n_cmp++;
        if (kick_log.size() - bk !== 1) begin
            n_bad++;
            $display("FAIL short_kicks got %0d want 1", kick_log.size() - bk);
        end else begin
            n_cmp++;
            if (kick_log[bk].cnt !== cnt || kick_log[bk].ov !== ov || kick_log[bk].ld !== 1'b1) begin
                n_bad++;
                $display("FAIL short_kick got cnt %0d ov %b ld %b want cnt %0d ov %b ld 1",
                         kick_log[bk].cnt, kick_log[bk].ov, kick_log[bk].ld, cnt, ov);
            end
            n_cmp++;
            if (wr_log.size() > bw && kick_log[bk].c !== wr_log[wr_log.size()-1].c + 1) begin
                n_bad++;
                $display("FAIL short_latency got %0d want %0d", kick_log[bk].c - wr_log[wr_log.size()-1].c, 1);
            end
        end
        n_cmp++;
        if (bw8 !== 0 || sd !== 1 || si !== 1 || st !== 0) begin
            n_bad++;
            $display("FAIL short_run got badwait %0d done %0d idle %0d stray %0d want 0 1 1 0", bw8, sd, si, st);
        end
    endtask

    task automatic test_full_frame();
        int bw, bk, acc, cnt, bw8, sd, si, st;
        bit ov;
        frame.delete();
        for (int i = 0; i < MEM_SIZE; i++) frame.push_back(32'(i + 1));
        bw = wr_log.size();
        bk = kick_log.size();
        model_frame(MEM_SIZE, MEM_SIZE - 1, cnt, ov);
        drive_frame(MEM_SIZE, MEM_SIZE - 1, 5, 1'b0, acc);
        complete_run(2, 1'b0, bw8, sd, si, st);
        n_cmp++;
        if (wr_log.size() - bw !== cnt) begin
            n_bad++;
            $display("FAIL full_nwr got %0d want %0d", wr_log.size() - bw, cnt);
        end
        for (int i = 0; i < cnt && bw + i < wr_log.size(); i++) begin
            n_cmp++;
            if (wr_log[bw+i].addr !== i || wr_log[bw+i].data !== frame[i]) begin
                n_bad++;
                $display("FAIL full_wr[%0d] got a=%0d d=%h want a=%0d d=%h", i, wr_log[bw+i].addr, wr_log[bw+i].data, i, frame[i]);
            end
        end
        n_cmp++;
        if (kick_log.size() - bk !== 1 || kick_log[bk].cnt !== cnt || kick_log[bk].ov !== ov) begin
            n_bad++;
            $display("FAIL full_kick got n %0d cnt %0d ov %b want n 1 cnt %0d ov %b",
                     kick_log.size() - bk, (kick_log.size() > bk) ? kick_log[bk].cnt : -1,
                     (kick_log.size() > bk) ? kick_log[bk].ov : 1'bx, cnt, ov);
        end
        n_cmp++;
        if (bw8 !== 0 || sd !== 1 || si !== 1 || st !== 0) begin
            n_bad++;
            $display("FAIL full_run got badwait %0d done %0d idle %0d stray %0d want 0 1 1 0", bw8, sd, si, st);
        end
    endtask

    task automatic test_overflow();
        int bw, bk, acc, cnt;
        bit ov;
        frame.delete();
        for (int i = 0; i < 300; i++) frame.push_back($urandom);
        bw = wr_log.size();
        bk = kick_log.size();
        model_frame(300, -1, cnt, ov);
        drive_frame(300, -1, 10, 1'b0, acc);
        n_cmp++;
        if (acc !== cnt || wr_log.size() - bw !== cnt) begin
            n_bad++;
            $display("FAIL ovf_accepted got acc %0d wr %0d want %0d", acc, wr_log.size() - bw, cnt);
        end
        for (int i = 0; i < cnt && bw + i < wr_log.size(); i++) begin
            n_cmp++;
            if (wr_log[bw+i].addr !== i || wr_log[bw+i].data !== frame[i]) begin
                n_bad++;
                $display("FAIL ovf_wr[%0d] got a=%0d d=%h want a=%0d d=%h", i, wr_log[bw+i].addr, wr_log[bw+i].data, i, frame[i]);
            end
        end
        n_cmp++;
        if (kick_log.size() - bk !== 1 || kick_log[bk].cnt !== cnt || kick_log[bk].ov !== ov) begin
            n_bad++;
            $display("FAIL ovf_kick got n %0d cnt %0d ov %b want n 1 cnt %0d ov %b",
                     kick_log.size() - bk, (kick_log.size() > bk) ? kick_log[bk].cnt : -1,
                     (kick_log.size() > bk) ? kick_log[bk].ov : 1'bx, cnt, ov);
        end
        @(negedge clk);
        n_cmp++;
        if (s_ready_o !== 1'b0 || overflow_o !== 1'b1 || wait_o !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_after got ready %b ovf %b wait %b want 0 1 1", s_ready_o, overflow_o, wait_o);
        end
        step();
    endtask

    // Continues from the truncated frame, still in WAIT.
    task automatic test_wait_done();
        int bw, bk, acc, bw8, sd, si, st;
        complete_run(20, 1'b1, bw8, sd, si, st);
        n_cmp++;
        if (bw8 !== 0 || sd !== 1 || si !== 1 || st !== 0) begin
            n_bad++;
            $display("FAIL wait_run got badwait %0d done %0d idle %0d stray %0d want 0 1 1 0", bw8, sd, si, st);
        end
        @(negedge clk);
        n_cmp++;
        if (overflow_o !== 1'b1) begin
            n_bad++;
            $display("FAIL wait_sticky got %b want 1", overflow_o);
        end
        step();
        frame.delete();
        for (int i = 0; i < 3; i++) frame.push_back($urandom);
        bw = wr_log.size();
        bk = kick_log.size();
        drive_frame(3, 2, 0, 1'b0, acc);
        complete_run(1, 1'b0, bw8, sd, si, st);
        n_cmp++;
        if (wr_log.size() - bw !== 3) begin
            n_bad++;
            $display("FAIL wait_next_nwr got %0d want 3", wr_log.size() - bw);
        end else begin
            n_cmp++;
            if (wr_log[bw].addr !== 0 || wr_log[bw].ov !== 1'b1 || wr_log[bw+1].ov !== 1'b0) begin
                n_bad++;
                $display("FAIL wait_next_first got a=%0d ov %b then %b want a=0 ov 1 then 0",
                         wr_log[bw].addr, wr_log[bw].ov, wr_log[bw+1].ov);
            end
        end
        n_cmp++;
        if (kick_log.size() - bk !== 1 || kick_log[bk].cnt !== 3 || kick_log[bk].ov !== 1'b0) begin
            n_bad++;
            $display("FAIL wait_next_kick got n %0d want n 1 cnt 3 ov 0", kick_log.size() - bk);
        end
    endtask

    task automatic test_reset_mid_load();
        int bw, bk, acc, bw8, sd, si, st;
        frame.delete();
        for (int i = 0; i < 10; i++) frame.push_back($urandom);
        bk = kick_log.size();
        drive_frame(10, -1, 20, 1'b0, acc);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (idle_o !== 1'b1 || load_o !== 1'b0 || s_ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_async got idle %b load %b ready %b want 1 0 1", idle_o, load_o, s_ready_o);
        end
        repeat (2) step();
        reset = 1'b0;
        repeat (3) step();
        n_cmp++;
        if (kick_log.size() !== bk) begin
            n_bad++;
            $display("FAIL rst_no_kick got %0d kicks want 0", kick_log.size() - bk);
        end
        frame.delete();
        for (int i = 0; i < 2; i++) frame.push_back($urandom);
        bw = wr_log.size();
        bk = kick_log.size();
        drive_frame(2, 1, 0, 1'b0, acc);
        complete_run(1, 1'b0, bw8, sd, si, st);
        n_cmp++;
        if (wr_log.size() - bw !== 2 || wr_log[bw].addr !== 0 || wr_log[bw+1].addr !== 1) begin
            n_bad++;
            $display("FAIL rst_next_wr got n %0d want 2 writes at 0,1", wr_log.size() - bw);
        end
        n_cmp++;
        if (kick_log.size() - bk !== 1 || kick_log[bk].cnt !== 2 || kick_log[bk].ov !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_next_kick got n %0d want n 1 cnt 2 ov 0", kick_log.size() - bk);
        end
    endtask

    task automatic test_random_frames();
        repeat (8) begin
            int n, bw, bk, acc, cnt, bw8, sd, si, st;
            bit ov;
            n = $urandom_range(1, 40);
            frame.delete();
            for (int i = 0; i < n; i++) frame.push_back($urandom);
            bw = wr_log.size();
            bk = kick_log.size();
            model_frame(n, n - 1, cnt, ov);
            drive_frame(n, n - 1, 30, 1'b1, acc);
            complete_run($urandom_range(0, 10), 1'b1, bw8, sd, si, st);
            n_cmp++;
            if (wr_log.size() - bw !== cnt) begin
                n_bad++;
                $display("FAIL rnd_nwr got %0d want %0d", wr_log.size() - bw, cnt);
            end
            for (int i = 0; i < cnt && bw + i < wr_log.size(); i++) begin
                n_cmp++;
                if (wr_log[bw+i].addr !== i || wr_log[bw+i].data !== frame[i]) begin
                    n_bad++;
                    $display("FAIL rnd_wr[%0d] got a=%0d d=%h want a=%0d d=%h", i, wr_log[bw+i].addr, wr_log[bw+i].data, i, frame[i]);
                end
            end
            n_cmp++;
            if (kick_log.size() - bk !== 1) begin
                n_bad++;
                $display("FAIL rnd_kicks got %0d want 1", kick_log.size() - bk);
            end else begin
                n_cmp++;
                if (kick_log[bk].cnt !== cnt || kick_log[bk].ov !== ov ||
                    (wr_log.size() > bw && kick_log[bk].c !== wr_log[wr_log.size()-1].c + 1)) begin
                    n_bad++;
                    $display("FAIL rnd_kick got cnt %0d ov %b want cnt %0d ov %b one cycle after last write",
                             kick_log[bk].cnt, kick_log[bk].ov, cnt, ov);
                end
            end
            n_cmp++;
            if (bw8 !== 0 || sd !== 1 || si !== 1 || st !== 0) begin
                n_bad++;
                $display("FAIL rnd_run got badwait %0d done %0d idle %0d stray %0d want 0 1 1 0", bw8, sd, si, st);
            end
        end
    endtask

    task automatic test_port_rules();
        n_cmp++;
        if (bad_port !== 0) begin
            n_bad++;
            $display("FAIL port_rules got %0d violations want 0", bad_port);
        end
        n_cmp++;
        if (bad_hot !== 0) begin
            n_bad++;
            $display("FAIL one_hot got %0d violations want 0", bad_hot);
        end
    endtask

    initial begin
        reset      = 1'b1;
        s_valid_i  = 1'b0;
        s_data_i   = '0;
        s_last_i   = 1'b0;
        acc_done_i = 1'b0;
        test_reset();
        test_short_frame();
        test_full_frame();
        test_overflow();
        test_wait_done();
        test_reset_mid_load();
        test_random_frames();
        test_port_rules();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
